// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding for the HC-05 link.
package uart_pkg;

    localparam int CLK_FREQ_HZ  = 50_000_000;
    localparam int BAUD         = 9600;
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int FRAME_BITS   = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: the first set request after ptr wins.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               any,
    output logic [IDW-1:0]     sel
);

    logic [IDW-1:0] idx;

    // Walk ptr+1, ptr+2, ... modulo NUM_REQ and keep the first valid index.
    always_comb begin
        any = 1'b0;
        sel = '0;
        idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[idx]) begin
                any = 1'b1;
                sel = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between several byte producers
// and times each frame itself, since uart_tx exposes no busy flag.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int FRAME_BITS   = uart_pkg::FRAME_BITS,
    parameter int GAP_BITS     = 1,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id
);

    localparam int FRAME_CLKS = (FRAME_BITS + GAP_BITS) * CLKS_PER_BIT;
    localparam int CW         = $clog2(FRAME_CLKS + 1);

    // The counter covers the HOLD cycles after the start pulse; it is loaded
    // two short so the IDLE decision cycle lands exactly FRAME_CLKS after it.
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CLKS - 2);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_HOLD = HOLD;

    logic [0:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;

    logic               pick_any;
    logic [IDW-1:0]     pick_sel;
    logic [7:0]         pick_byte;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .sel (pick_sel)
    );

    // Mux out the byte of the selected requester.
    always_comb begin
        pick_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_sel == IDW'(i)) begin
                pick_byte = req_data[8*i +: 8];
            end
        end
    end

    // Next-state logic: grant in IDLE, then count out the frame in HOLD.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        grant_id_d  = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (pick_any) begin
                    state_d    = ST_HOLD;
                    cnt_d      = CNT_LOAD;
                    ptr_d      = pick_sel;
                    tx_start_d = 1'b1;
                    tx_data_d  = pick_byte;
                    busy_d     = 1'b1;
                    grant_id_d = pick_sel;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_ready_d[i] = (pick_sel == IDW'(i));
                    end
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ptr_q       <= IDW'(NUM_REQ - 1);
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            grant_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            grant_id_q  <= grant_id_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule
